// File: rtl/vend_ctrl_param.sv
// Vending controller: N-item price table, capped credit, cancel/timeout refund,
// greedy coin-by-coin change over a valid/ready handshake.
module vend_ctrl_param #(
    parameter int                            NUM_ITEMS   = 4,
    parameter int                            MONEY_W     = 8,
    parameter logic [NUM_ITEMS*MONEY_W-1:0]  PRICE_LIST  = {8'd5, 8'd20, 8'd14, 8'd10},
    parameter int                            COIN_HI     = 10,
    parameter int                            COIN_MID    = 5,
    parameter int                            COIN_LO     = 1,
    parameter int                            CREDIT_MAX  = 99,
    parameter int                            TIMEOUT_CYC = 1000
) (
    input  logic                          CLOCK_27,
    input  logic                          RESET,
    input  logic                          sel_valid,
    input  logic [$clog2(NUM_ITEMS)-1:0]  sel_item,
    input  logic [2:0]                    coin_in,
    input  logic                          cancel,
    input  logic                          confirm,
    input  logic                          ack,
    input  logic                          coin_out_ready,
    output logic                          coin_out_valid,
    output logic [2:0]                    coin_out,
    output logic                          vend_pulse,
    output logic                          coin_reject,
    output logic [2:0]                    state_code,
    output logic [MONEY_W-1:0]            credit,
    output logic [MONEY_W-1:0]            price,
    output logic [MONEY_W-1:0]            change_due
);
    localparam int SEL_W = $clog2(NUM_ITEMS);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PAY     = 3'd1,
        S_CONFIRM = 3'd2,
        S_VEND    = 3'd3,
        S_REFUND  = 3'd4,
        S_CHANGE  = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [MONEY_W-1:0] credit_q, credit_d;
    logic [MONEY_W-1:0] price_q, price_d;
    logic [MONEY_W-1:0] change_q, change_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [2:0]         coin_q, coin_d;
    logic               cov_q, cov_d;
    logic               vend_q, vend_d;
    logic               reject_q, reject_d;

    function automatic logic [MONEY_W-1:0] denom(input logic [2:0] c);
        case (c)
            3'b100:  denom = MONEY_W'(COIN_HI);
            3'b010:  denom = MONEY_W'(COIN_MID);
            3'b001:  denom = MONEY_W'(COIN_LO);
            default: denom = '0;
        endcase
    endfunction

    // Largest denomination that fits; 0 when nothing fits (owed amount exhausted).
    function automatic logic [2:0] greedy(input logic [MONEY_W-1:0] amt);
        if (amt >= MONEY_W'(COIN_HI))       greedy = 3'b100;
        else if (amt >= MONEY_W'(COIN_MID)) greedy = 3'b010;
        else if (amt >= MONEY_W'(COIN_LO))  greedy = 3'b001;
        else                                greedy = 3'b000;
    endfunction

    logic [MONEY_W-1:0] sel_price;
    logic               sel_ok;
    logic               coin_one_hot;
    logic [MONEY_W:0]   coin_sum;
    logic               coin_ok;
    logic               tmo_hit;

    always_comb begin
        sel_price = '0;
        for (int i = 0; i < NUM_ITEMS; i++)
            if (SEL_W'(i) == sel_item) sel_price = PRICE_LIST[i*MONEY_W +: MONEY_W];
    end

    assign sel_ok       = {1'b0, sel_item} < (SEL_W+1)'(NUM_ITEMS);
    assign coin_one_hot = (coin_in == 3'b001) || (coin_in == 3'b010) || (coin_in == 3'b100);
    // One extra bit so the ceiling compare cannot be fooled by wrap.
    assign coin_sum     = {1'b0, credit_q} + {1'b0, denom(coin_in)};
    assign coin_ok      = (state_q == S_PAY) && coin_one_hot &&
                          (coin_sum <= (MONEY_W+1)'(CREDIT_MAX));
    assign tmo_hit      = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        price_d  = price_q;
        change_d = change_q;
        tmo_d    = tmo_q;
        reject_d = (coin_in != 3'b000) && !coin_ok;
        if (coin_ok) credit_d = coin_sum[MONEY_W-1:0];

        case (state_q)
            S_IDLE: begin
                if (sel_valid && sel_ok) begin
                    price_d = sel_price;
                    state_d = S_PAY;
                end
            end
            S_PAY: begin
                if (cancel || tmo_hit)       state_d = S_REFUND;
                else if (credit_q >= price_q) state_d = S_CONFIRM;
                else if (sel_valid && sel_ok) price_d = sel_price;
            end
            S_CONFIRM: begin
                if (cancel || tmo_hit) state_d = S_REFUND;
                else if (confirm)      state_d = S_VEND;
            end
            S_VEND: begin
                change_d = credit_q - price_q;
                credit_d = '0;
                state_d  = (credit_q != price_q) ? S_CHANGE : S_DONE;
            end
            S_REFUND: begin
                change_d = credit_q;
                credit_d = '0;
                state_d  = (credit_q != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                if (cov_q && coin_out_ready) change_d = change_q - denom(coin_q);
                else if (!cov_q)             state_d  = S_DONE;
            end
            S_DONE: begin
                if (ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_IDLE) begin
            credit_d = '0;
            price_d  = '0;
            change_d = '0;
        end

        if (state_d != state_q || coin_ok || (sel_valid && state_q == S_PAY))
            tmo_d = '0;
        else if (state_q == S_PAY || state_q == S_CONFIRM)
            tmo_d = tmo_q + 1'b1;

        // Offer is a function of the owed amount only, so it holds while ready is low.
        coin_d = (state_d == S_CHANGE) ? greedy(change_d) : 3'b000;
        cov_d  = (coin_d != 3'b000);
        vend_d = (state_d == S_VEND);
    end

    always_ff @(posedge CLOCK_27 or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            credit_q <= '0;
            price_q  <= '0;
            change_q <= '0;
            tmo_q    <= '0;
            coin_q   <= 3'b000;
            cov_q    <= 1'b0;
            vend_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            price_q  <= price_d;
            change_q <= change_d;
            tmo_q    <= tmo_d;
            coin_q   <= coin_d;
            cov_q    <= cov_d;
            vend_q   <= vend_d;
            reject_q <= reject_d;
        end
    end

    assign coin_out_valid = cov_q;
    assign coin_out       = coin_q;
    assign vend_pulse     = vend_q;
    assign coin_reject    = reject_q;
    assign state_code     = state_q;
    assign credit         = credit_q;
    assign price          = price_q;
    assign change_due     = change_q;
endmodule

// File: tb/tb_vend_ctrl_param.sv
// Directed bench for vend_ctrl_param; output events are checked against a
// queue of expected events by an independent negedge monitor.
module tb_vend_ctrl_param;
    localparam int TMO = 1000;

    logic       CLOCK_27 = 1'b0;
    logic       RESET, sel_valid, cancel, confirm, ack, coin_out_ready;
    logic [1:0] sel_item;
    logic [2:0] coin_in;
    logic       coin_out_valid, vend_pulse, coin_reject;
    logic [2:0] coin_out, state_code;
    logic [7:0] credit, price, change_due;

    always #5 CLOCK_27 = ~CLOCK_27;

    // Item3 is priced at 99 so credit can be built up near the ceiling in PAY.
    vend_ctrl_param #(
        .NUM_ITEMS(4), .MONEY_W(8),
        .PRICE_LIST({8'd99, 8'd20, 8'd14, 8'd10}),
        .COIN_HI(10), .COIN_MID(5), .COIN_LO(1),
        .CREDIT_MAX(99), .TIMEOUT_CYC(TMO)
    ) dut (
        .CLOCK_27(CLOCK_27), .RESET(RESET),
        .sel_valid(sel_valid), .sel_item(sel_item), .coin_in(coin_in),
        .cancel(cancel), .confirm(confirm), .ack(ack),
        .coin_out_ready(coin_out_ready), .coin_out_valid(coin_out_valid),
        .coin_out(coin_out), .vend_pulse(vend_pulse), .coin_reject(coin_reject),
        .state_code(state_code), .credit(credit), .price(price),
        .change_due(change_due)
    );

    // kind: 0 coin handshake (val = one-hot coin), 1 vend (val = credit), 2 reject (val = credit)
    typedef struct { int kind; int val; } ev_t;
    ev_t exp_q[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic got(input int k, input int v, input string nm);
        ev_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_%s: got value %0d expected no event", nm, v);
        end else begin
            e = exp_q.pop_front();
            check({nm, "_kind"}, k, e.kind);
            check({nm, "_val"}, v, e.val);
        end
    endtask

    always @(negedge CLOCK_27) begin
        if (!RESET) begin
            if (coin_out_valid && coin_out_ready) got(0, int'(coin_out), "coin");
            if (vend_pulse)  got(1, int'(credit), "vend");
            if (coin_reject) got(2, int'(credit), "reject");
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_27);
        #1;
    endtask

    task automatic do_sel(input int i);
        sel_valid = 1'b1;
        sel_item  = 2'(i);
        tick(1);
        sel_valid = 1'b0;
    endtask

    task automatic do_coin(input logic [2:0] c);
        coin_in = c;
        tick(1);
        coin_in = 3'b000;
    endtask

    task automatic pulse_cancel();  cancel = 1'b1;  tick(1); cancel = 1'b0;  endtask
    task automatic pulse_confirm(); confirm = 1'b1; tick(1); confirm = 1'b0; endtask
    task automatic pulse_ack();     ack = 1'b1;     tick(1); ack = 1'b0;     endtask

    task automatic wait_state(input int s, input int budget, input string name);
        int n;
        n = 0;
        while (int'(state_code) != s && n < budget) begin
            tick(1);
            n++;
        end
        check(name, int'(state_code), s);
    endtask

    task automatic count_to_refund(input string name);
        int n;
        n = 0;
        while (state_code != 3'd4 && n < 2 * TMO) begin
            tick(1);
            n++;
        end
        check(name, n, TMO);
    endtask

    initial begin
        RESET = 1'b1; sel_valid = 1'b0; sel_item = 2'd0; coin_in = 3'b000;
        cancel = 1'b0; confirm = 1'b0; ack = 1'b0; coin_out_ready = 1'b1;
        tick(3);
        check("rst_state", int'(state_code), 0);
        check("rst_credit", int'(credit), 0);
        check("rst_price", int'(price), 0);
        check("rst_change", int'(change_due), 0);
        check("rst_outs", int'({coin_out_valid, coin_out, vend_pulse, coin_reject}), 0);
        RESET = 1'b0;
        tick(1);

        // Item1 (14), pay 20, change 6 as mid then lo.
        do_sel(1);
        check("t1_state_pay", int'(state_code), 1);
        check("t1_price", int'(price), 14);
        do_coin(3'b100);
        do_coin(3'b100);
        check("t1_credit", int'(credit), 20);
        tick(1);
        check("t1_state_confirm", int'(state_code), 2);
        push(1, 20); push(0, 2); push(0, 1);
        pulse_confirm();
        check("t1_state_vend", int'(state_code), 3);
        wait_state(6, 20, "t1_done");
        check("t1_change_zero", int'(change_due), 0);
        pulse_ack();
        check("t1_idle", int'(state_code), 0);
        check("t1_idle_price", int'(price), 0);
        check("t1_idle_credit", int'(credit), 0);

        // Cancel with 6 credited: refund mid then lo, no vend.
        do_sel(0);
        do_coin(3'b010);
        do_coin(3'b001);
        check("t2_credit", int'(credit), 6);
        push(0, 2); push(0, 1);
        pulse_cancel();
        check("t2_refund", int'(state_code), 4);
        wait_state(6, 20, "t2_done");
        pulse_ack();
        check("t2_idle", int'(state_code), 0);

        // Timeout with 5 credited: refund one mid coin.
        do_sel(2);
        do_coin(3'b010);
        push(0, 2);
        count_to_refund("t3_timeout_cycles");
        wait_state(6, 20, "t3_done");
        pulse_ack();
        check("t3_idle", int'(state_code), 0);

        // Timeout with no credit: REFUND then straight to IDLE.
        do_sel(2);
        count_to_refund("t3b_timeout_cycles");
        tick(1);
        check("t3b_idle", int'(state_code), 0);

        // Rejections: coin in IDLE, multi-bit coin, overflow past the ceiling.
        push(2, 0);
        do_coin(3'b100);
        check("t4_idle_credit", int'(credit), 0);
        do_sel(2);
        push(2, 0);
        do_coin(3'b110);
        check("t4_multibit_credit", int'(credit), 0);
        pulse_cancel();
        tick(1);
        check("t4_cancel_idle", int'(state_code), 0);
        do_sel(3);
        repeat (9) do_coin(3'b100);
        do_coin(3'b010);
        check("t4_credit95", int'(credit), 95);
        push(2, 95);
        do_coin(3'b100);
        check("t4_overflow_credit", int'(credit), 95);
        repeat (4) do_coin(3'b001);
        check("t4_credit_max", int'(credit), 99);
        tick(1);
        check("t4_confirm_state", int'(state_code), 2);
        repeat (9) push(0, 4);
        push(0, 2);
        repeat (4) push(0, 1);
        confirm = 1'b1; cancel = 1'b1;
        tick(1);
        confirm = 1'b0; cancel = 1'b0;
        check("t4_cancel_beats_confirm", int'(state_code), 4);
        wait_state(6, 60, "t4_done");
        pulse_ack();

        // Change 16 via reselect; hold ready low and check the offer is stable.
        do_sel(3);
        do_coin(3'b100); do_coin(3'b100); do_coin(3'b010); do_coin(3'b001);
        check("t5_credit", int'(credit), 26);
        do_sel(0);
        check("t5_reselect_price", int'(price), 10);
        tick(1);
        check("t5_confirm", int'(state_code), 2);
        coin_out_ready = 1'b0;
        push(1, 26);
        pulse_confirm();
        tick(1);
        for (int i = 0; i < 3; i++) begin
            check("t5_hold_valid", int'(coin_out_valid), 1);
            check("t5_hold_coin", int'(coin_out), 4);
            check("t5_hold_change", int'(change_due), 16);
            tick(1);
        end
        push(0, 4); push(0, 2); push(0, 1);
        coin_out_ready = 1'b1;
        wait_state(6, 20, "t5_done");
        check("t5_change_zero", int'(change_due), 0);
        pulse_ack();

        // Reset while 6 is owed: nothing further is dispensed.
        do_sel(1);
        do_coin(3'b100); do_coin(3'b100);
        tick(1);
        coin_out_ready = 1'b0;
        push(1, 20);
        pulse_confirm();
        tick(1);
        check("t6_change_state", int'(state_code), 5);
        check("t6_change_owed", int'(change_due), 6);
        RESET = 1'b1;
        #1;
        check("t6_rst_state", int'(state_code), 0);
        check("t6_rst_valid", int'(coin_out_valid), 0);
        check("t6_rst_change", int'(change_due), 0);
        tick(2);
        RESET = 1'b0;
        coin_out_ready = 1'b1;
        tick(10);
        check("t6_no_coin", int'(coin_out_valid), 0);
        check("t6_still_idle", int'(state_code), 0);

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
